// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Bundles the receiver-facing and host-facing signals of uart_rx_fifo.
//   Receiver side : rx_done, rx_dout, parity_error_flag, framing_error_flag -> rx_start
//   Host side     : en, rd_en, clr_flags -> rd_data, rd_valid, empty, full, count,
//                   overrun, parity_err_cnt, framing_err_cnt
//   modport slave  : the FIFO block
//   modport master : whatever drives it (receiver + host, or a testbench)
interface uart_rx_fifo_if #(
   parameter int data_wd = 8,
   parameter int depth   = 16,
   parameter int cnt_wd  = 8
) ();
   localparam int CW = $clog2(depth + 1);

   logic               en;
   logic               rx_done;
   logic [data_wd-1:0] rx_dout;
   logic               parity_error_flag;
   logic               framing_error_flag;
   logic               rx_start;
   logic               rd_en;
   logic [data_wd-1:0] rd_data;
   logic               rd_valid;
   logic               empty;
   logic               full;
   logic [CW-1:0]      count;
   logic               overrun;
   logic [cnt_wd-1:0]  parity_err_cnt;
   logic [cnt_wd-1:0]  framing_err_cnt;
   logic               clr_flags;

   modport slave (
      input  en, rx_done, rx_dout, parity_error_flag, framing_error_flag,
             rd_en, clr_flags,
      output rx_start, rd_data, rd_valid, empty, full, count, overrun,
             parity_err_cnt, framing_err_cnt
   );

   modport master (
      output en, rx_done, rx_dout, parity_error_flag, framing_error_flag,
             rd_en, clr_flags,
      input  rx_start, rd_data, rd_valid, empty, full, count, overrun,
             parity_err_cnt, framing_err_cnt
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive buffer behind a UART receiver. Each rising edge of rx_done stores
//   rx_dout into a circular FIFO; the host pops through a registered read port
//   (rd_data + one-cycle rd_valid). rx_start tells the receiver whether there
//   will be room for another frame. Parity/framing flag rising edges feed
//   saturating counters; a frame arriving while full sets a sticky overrun.
//   Ports: clk, rst (async, active low), bus (uart_rx_fifo_if.slave).
module uart_rx_fifo #(
   parameter int data_wd = 8,
   parameter int depth   = 16,
   parameter int cnt_wd  = 8
) (
   input  logic              clk,
   input  logic              rst,
   uart_rx_fifo_if.slave     bus
);
   localparam int                PW      = $clog2(depth);
   localparam int                CW      = $clog2(depth + 1);
   localparam logic [CW-1:0]     DEPTH_C = CW'(depth);
   localparam logic [cnt_wd-1:0] CNT_MAX = '1;

   logic [data_wd-1:0] mem [depth];
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [CW-1:0]      count_q, count_next;
   logic               rx_done_d, perr_d, ferr_d;
   logic               rx_start_q, overrun_q;
   logic [data_wd-1:0] rd_data_q;
   logic [cnt_wd-1:0]  perr_cnt, ferr_cnt;
   logic [1:0]         vld_pipe;

   logic empty_w, full_w, push, perr_evt, ferr_evt, rd_accept, wr_ok, drop;

   assign empty_w   = (count_q == '0);
   assign full_w    = (count_q == DEPTH_C);
   assign push      = bus.rx_done & ~rx_done_d;
   assign perr_evt  = bus.parity_error_flag & ~perr_d;
   assign ferr_evt  = bus.framing_error_flag & ~ferr_d;
   assign rd_accept = bus.rd_en & ~empty_w;
   // A full FIFO still takes the frame if the slot is being vacated this cycle.
   assign wr_ok     = push & (~full_w | rd_accept);
   assign drop      = push & full_w & ~rd_accept;
   assign vld_pipe[0] = rd_accept;

   always_comb begin
      count_next = count_q;
      case ({wr_ok, rd_accept})
         2'b10:   count_next = count_q + CW'(1);
         2'b01:   count_next = count_q - CW'(1);
         default: count_next = count_q;
      endcase
   end

   // Storage has no reset; contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= bus.rx_dout;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         rx_done_d   <= 1'b0;
         perr_d      <= 1'b0;
         ferr_d      <= 1'b0;
         rx_start_q  <= 1'b0;
         rd_data_q   <= '0;
         vld_pipe[1] <= 1'b0;
      end else begin
         rx_done_d   <= bus.rx_done;
         perr_d      <= bus.parity_error_flag;
         ferr_d      <= bus.framing_error_flag;
         count_q     <= count_next;
         // Looks at the post-update count so permission tracks fill/drain
         // with a single cycle of lag.
         rx_start_q  <= bus.en & (count_next < DEPTH_C);
         vld_pipe[1] <= vld_pipe[0];
         if (wr_ok)     wr_ptr <= wr_ptr + PW'(1);
         if (rd_accept) begin
            rd_ptr    <= rd_ptr + PW'(1);
            rd_data_q <= mem[rd_ptr];
         end
      end
   end

   // Clear wins over a same-cycle event, which is then lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overrun_q <= 1'b0;
         perr_cnt  <= '0;
         ferr_cnt  <= '0;
      end else if (bus.clr_flags) begin
         overrun_q <= 1'b0;
         perr_cnt  <= '0;
         ferr_cnt  <= '0;
      end else begin
         if (drop) overrun_q <= 1'b1;
         if (perr_evt && perr_cnt != CNT_MAX) perr_cnt <= perr_cnt + cnt_wd'(1);
         if (ferr_evt && ferr_cnt != CNT_MAX) ferr_cnt <= ferr_cnt + cnt_wd'(1);
      end
   end

   assign bus.rx_start        = rx_start_q;
   assign bus.rd_data         = rd_data_q;
   assign bus.rd_valid        = vld_pipe[1];
   assign bus.empty           = empty_w;
   assign bus.full            = full_w;
   assign bus.count           = count_q;
   assign bus.overrun         = overrun_q;
   assign bus.parity_err_cnt  = perr_cnt;
   assign bus.framing_err_cnt = ferr_cnt;
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   uart_rx_fifo_if #(.data_wd(8), .depth(16), .cnt_wd(8)) bus ();

   uart_rx_fifo #(.data_wd(8), .depth(16), .cnt_wd(8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Monitor: every rd_valid pulse must match the oldest outstanding read.
   always @(negedge clk) begin
      if (rst && bus.rd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_valid_unexpected got data=%02h with no read outstanding", bus.rd_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (bus.rd_data !== e) begin
               errors++;
               $display("FAIL rd_data got=%02h exp=%02h", bus.rd_data, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic push_frame(input logic [7:0] d, input int hold);
      bus.rx_dout = d;
      bus.rx_done = 1'b1;
      repeat (hold) tick();
      bus.rx_done = 1'b0;
      tick();
   endtask

   task automatic rd(input logic [7:0] e);
      bus.rd_en = 1'b1;
      exp_q.push_back(e);
      tick();
      bus.rd_en = 1'b0;
   endtask

   initial begin
      bus.en = 1'b0; bus.rx_done = 1'b0; bus.rx_dout = '0;
      bus.parity_error_flag = 1'b0; bus.framing_error_flag = 1'b0;
      bus.rd_en = 1'b0; bus.clr_flags = 1'b0;
      #12;
      // reset state
      check("rst_count", bus.count, 0);
      check("rst_empty", bus.empty, 1);
      check("rst_full", bus.full, 0);
      check("rst_rx_start", bus.rx_start, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_rd_data", bus.rd_data, 0);
      check("rst_overrun", bus.overrun, 0);
      check("rst_perr", bus.parity_err_cnt, 0);
      rst = 1'b1;
      bus.en = 1'b1;
      tick();
      check("rx_start_after_en", bus.rx_start, 1);

      // two frames, rx_done held 3 cycles each -> exactly two entries
      push_frame(8'hA5, 3);
      push_frame(8'h3C, 3);
      check("count_two", bus.count, 2);
      rd(8'hA5);
      rd(8'h3C);
      tick();
      check("empty_after_two", bus.empty, 1);
      // read on empty: no rd_valid (monitor flags any pulse)
      bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0; tick();
      check("empty_read_count", bus.count, 0);

      // fill, overflow, drain
      for (int i = 0; i < 16; i++) push_frame(8'(i), 1);
      check("full", bus.full, 1);
      check("rx_start_full", bus.rx_start, 0);
      push_frame(8'hFF, 1);
      check("overrun_set", bus.overrun, 1);
      check("count_after_drop", bus.count, 16);
      for (int i = 0; i < 16; i++) begin
         rd(8'(i));
         if (i == 0) check("rx_start_reassert", bus.rx_start, 1);
      end
      check("empty_after_drain", bus.empty, 1);
      bus.clr_flags = 1'b1; tick(); bus.clr_flags = 1'b0;
      check("overrun_clr", bus.overrun, 0);

      // simultaneous push and read while full
      for (int i = 0; i < 16; i++) push_frame(8'h20 + 8'(i), 1);
      bus.rx_dout = 8'h55; bus.rx_done = 1'b1; bus.rd_en = 1'b1;
      exp_q.push_back(8'h20);
      tick();
      bus.rx_done = 1'b0; bus.rd_en = 1'b0;
      check("full_rw_count", bus.count, 16);
      check("full_rw_overrun", bus.overrun, 0);
      tick();
      for (int i = 1; i < 16; i++) rd(8'h20 + 8'(i));
      rd(8'h55);
      check("empty_after_rw", bus.empty, 1);

      // 20 rounds of two writes + two reads + one empty read: 40 writes wrap twice
      for (int i = 0; i < 20; i++) begin
         push_frame(8'h80 + 8'(2*i), 1);
         push_frame(8'h81 + 8'(2*i), 2);
         if (i == 7) check("wrap_count2", bus.count, 2);
         rd(8'h80 + 8'(2*i));
         rd(8'h81 + 8'(2*i));
         bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
      end
      check("wrap_empty", bus.empty, 1);

      // error counters
      for (int i = 0; i < 300; i++) begin
         bus.parity_error_flag = 1'b1; tick();
         bus.parity_error_flag = 1'b0; tick();
      end
      check("perr_sat", bus.parity_err_cnt, 255);
      bus.framing_error_flag = 1'b1; repeat (10) tick();
      bus.framing_error_flag = 1'b0; tick();
      check("ferr_held", bus.framing_err_cnt, 1);
      bus.clr_flags = 1'b1; bus.parity_error_flag = 1'b1; tick();
      bus.clr_flags = 1'b0; bus.parity_error_flag = 1'b0; tick();
      check("clr_priority_perr", bus.parity_err_cnt, 0);
      check("clr_ferr", bus.framing_err_cnt, 0);
      bus.parity_error_flag = 1'b1; tick(); bus.parity_error_flag = 1'b0; tick();
      check("perr_one", bus.parity_err_cnt, 1);

      // asynchronous reset mid-push with five entries stored
      for (int i = 0; i < 6; i++) push_frame(8'h40 + 8'(i), 1);
      rd(8'h40);
      tick();
      check("pre_rst_count", bus.count, 5);
      bus.rx_dout = 8'h77; bus.rx_done = 1'b1;
      #2 rst = 1'b0;
      #1;
      check("arst_count", bus.count, 0);
      check("arst_empty", bus.empty, 1);
      check("arst_rx_start", bus.rx_start, 0);
      check("arst_rd_data", bus.rd_data, 0);
      check("arst_perr", bus.parity_err_cnt, 0);
      bus.rx_done = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("post_rst_rx_start", bus.rx_start, 1);
      check("post_rst_empty", bus.empty, 1);

      repeat (3) tick();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. Captures each completed frame (receiver `dout` qualified by a rising edge of `rx_done`) into a circular FIFO. Presents the data to the host through a registered read port. Drives the receiver's `rx_start` enable from FIFO space, and keeps sticky overrun and saturating error counters from the receiver's parity and framing flags.

Parameters:
data_wd, 8, frame data width; matches the receiver `data_wd`
depth, 16, FIFO entries; must be a power of 2, ≥2
cnt_wd, 8, width of each error counter

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous, active-low reset (asserted when 0)
en  input  1  host receive enable
rx_done  input  1  receiver frame-complete level; may stay high for more than one cycle
rx_dout  input  data_wd  receiver parallel data; valid while rx_done=1
parity_error_flag  input  1  receiver parity error level
framing_error_flag  input  1  receiver framing error level
rx_start  output  1  receive permission to the receiver (registered)
rd_en  input  1  host read request
rd_data  output  data_wd  read data (registered)
rd_valid  output  1  one-cycle pulse: rd_data updated
empty  output  1  count==0
full  output  1  count==depth
count  output  $clog2(depth+1)  entries stored
overrun  output  1  sticky: a frame was dropped while full
parity_err_cnt  output  cnt_wd  saturating count of parity errors
framing_err_cnt  output  cnt_wd  saturating count of framing errors
clr_flags  input  1  synchronous clear of overrun and both error counters

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=rd_ptr=0, count=0, rx_start=0, rd_data=0, rd_valid=0, overrun=0, both counters=0, all edge-detect registers=0. Memory contents are don't-care.
- Edge detect: registered copies of rx_done and both error flags.
  - push = rx_done & ~rx_done_d; one push per frame regardless of how long rx_done is held.
  - perr_evt = parity_error_flag & ~its delayed copy; ferr_evt likewise for framing_error_flag.
- Write, on a push cycle:
  - If not full, or if full and rd_accept is true in the same cycle: mem[wr_ptr] <= rx_dout; wr_ptr wraps depth-1→0.
  - If full and no rd_accept: frame dropped, pointers unchanged, overrun <= 1.
- Read:
  - rd_accept = rd_en & ~empty.
  - On accept: rd_data <= mem[rd_ptr], rd_ptr wraps, rd_valid=1 the next cycle for exactly one cycle.
  - rd_en while empty: ignored; rd_data holds, rd_valid=0, no underflow.
  - A push into an empty FIFO is not readable in the same cycle (no bypass). It is readable from the following cycle.
- count: +1 on write only, −1 on read only, unchanged on both or neither. empty and full are decoded combinationally from the registered count. Latency from push to empty=0 is 1 clock.
- rx_start <= en & (count_next < depth), where count_next is the post-update count. rx_start drops the cycle after the FIFO becomes full and re-asserts the cycle after the first read frees a slot. en=0 forces rx_start=0 next cycle; a frame already in progress still completes and is stored if space exists.
- Error counters:
  - On each event, increment the corresponding counter, saturating at 2^cnt_wd−1 with no wrap.
  - Error frames never produce rx_done, so nothing is pushed for them.
- clr_flags: overrun and counters <= 0 next edge. clr_flags has priority over a same-cycle event, so that event is lost. FIFO contents and pointers are unaffected.
- Reset mid-operation: all state returns to reset values immediately; stored data is discarded.

Test Plan:
- Reset, en=1, push 0xA5 then 0x3C (rx_done held 3 cycles each), then rd_en twice → exactly 2 entries, count=2; rd_data=0xA5 then 0x3C with rd_valid pulses; empty=1 afterwards.
- Fill all 16 entries (0x00–0x0F) → full=1, rx_start=0 next cycle. Push 0xFF → dropped, overrun=1. Read all → 0x00–0x0F in order. clr_flags → overrun=0.
- Full FIFO with push 0x55 and rd_en in the same cycle → read returns the oldest entry, 0x55 is stored, count stays 16, overrun stays 0.
- 20 write/read cycles crossing the pointer wrap twice → data order preserved, count never exceeds 16, rd_en on empty gives no rd_valid.
- 300 parity_error_flag rising edges (cnt_wd=8) → parity_err_cnt=255. Framing flag held high 10 cycles → framing_err_cnt=1.
- rst=0 asserted with count=5 mid-push → immediately count=0, empty=1, rx_start=0, rd_data=0. After release with en=1, rx_start=1 on the next edge.
